// File: rtl/app_nch_sampler.sv
// ---------------------------------------------------------------------------
// app_nch_sampler
// Multi-channel TOT event sampler. Each comparator channel is synchronised and
// edge-detected. A small per-channel FSM then allocates each event to an
// alternating ping (sample) / pong (sampleP) slot, fires front/back TAC pulses
// per event index, counts events and applies an optional timeout.
//
// Ports
//   clk             system clock
//   rst_init_n      asynchronous active-low reset
//   read_en         synchronous clear of counts, flags, slots and event index
//   timeout_en      enable the post-fall timeout
//   timeout_length  timeout in clk cycles after the synced fall (0 acts as 1)
//   vcomp           asynchronous TOT level per channel
//   sample/sampleP  held ping/pong slot bits, channel c at [c*NSLOT +: NSLOT]
//   VP_front        rise TAC pulse per event index, channel c at [c*2*NSLOT +: 2*NSLOT]
//   VP_back         fall TAC pulse per event index, same packing
//   count           saturating event count per channel, CW bits each
//   overflow        sticky, set when the event index wraps to 0
//   timeout         one-cycle pulse when the timeout expires
//
// Configuration macro
//   APP_GLITCH_FILTER_EN : when defined, the synced level must be stable for
//   two consecutive cycles before an edge is accepted (one extra cycle of
//   latency, pulses shorter than two cycles are ignored).
// ---------------------------------------------------------------------------
module app_nch_sampler #(
    parameter int NCH     = 4,
    parameter int NSLOT   = 4,
    parameter int PULSE_W = 2,
    parameter int TO_W    = 6
) (
    input  logic                                 clk,
    input  logic                                 rst_init_n,
    input  logic                                 read_en,
    input  logic                                 timeout_en,
    input  logic [TO_W-1:0]                      timeout_length,
    input  logic [NCH-1:0]                       vcomp,
    output logic [NCH*NSLOT-1:0]                 sample,
    output logic [NCH*NSLOT-1:0]                 sampleP,
    output logic [NCH*2*NSLOT-1:0]               VP_front,
    output logic [NCH*2*NSLOT-1:0]               VP_back,
    output logic [NCH*$clog2(2*NSLOT+1)-1:0]     count,
    output logic [NCH-1:0]                       overflow,
    output logic [NCH-1:0]                       timeout
);

    localparam int NEV = 2 * NSLOT;
    localparam int EW  = (NEV > 2) ? $clog2(NEV) : 1;
    localparam int CW  = $clog2(NEV + 1);
    localparam int PW  = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    for (genvar c = 0; c < NCH; c++) begin : gen_ch
        logic            sync1_r, sync2_r, sync3_r;
        logic            rise_s, fall_s;
        state_t          state_r;
        logic [EW-1:0]   ev_r, ev_base_s, ev_inc_s, prev_idx_s;
        logic [CW-1:0]   count_r, count_base_s;
        logic [NEV-1:0]  held_r, held_base_s, prev_mask_s, front_mask_s;
        logic            ovf_r, ovf_base_s, wrap_s;
        logic [TO_W-1:0] timer_r, tload_s;
        logic            timeout_r;
        logic            front_go_s, back_go_s;

        // Two-flop synchroniser plus one delayed copy for edge detection
        always_ff @(posedge clk or negedge rst_init_n) begin
            if (!rst_init_n) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
                sync3_r <= 1'b0;
            end else begin
                sync1_r <= vcomp[c];
                sync2_r <= sync1_r;
                sync3_r <= sync2_r;
            end
        end

`ifdef APP_GLITCH_FILTER_EN
        logic filt_r;

        // Filtered level only follows the synced level once it held for two cycles
        always_ff @(posedge clk or negedge rst_init_n) begin
            if (!rst_init_n) begin
                filt_r <= 1'b0;
            end else if (sync2_r == sync3_r) begin
                filt_r <= sync2_r;
            end else begin
                filt_r <= filt_r;
            end
        end

        // Edges are accepted against the filtered level
        always_comb begin
            rise_s = sync2_r & sync3_r & ~filt_r;
            fall_s = ~sync2_r & ~sync3_r & filt_r;
        end
`else
        // Edges taken directly from the synced level and its delayed copy
        always_comb begin
            rise_s = sync2_r & ~sync3_r;
            fall_s = ~sync2_r & sync3_r;
        end
`endif

        // read_en clears first; every update below starts from these base values
        always_comb begin
            ev_base_s    = read_en ? {EW{1'b0}}  : ev_r;
            count_base_s = read_en ? {CW{1'b0}}  : count_r;
            held_base_s  = read_en ? {NEV{1'b0}} : held_r;
            ovf_base_s   = read_en ? 1'b0        : ovf_r;
            wrap_s       = (ev_base_s == EW'(NEV - 1));
            ev_inc_s     = wrap_s ? {EW{1'b0}} : (ev_base_s + EW'(1));
            // Previous event sits in the opposite bank; its bit is released at this fall
            prev_idx_s   = (ev_r == {EW{1'b0}}) ? EW'(NEV - 1) : (ev_r - EW'(1));
            prev_mask_s  = {NEV{1'b0}};
            prev_mask_s[prev_idx_s] = 1'b1;
            front_mask_s = {NEV{1'b0}};
            front_mask_s[ev_base_s] = 1'b1;
            tload_s      = (timeout_length == {TO_W{1'b0}}) ? TO_W'(1) : timeout_length;
            front_go_s   = (state_r != ST_HIGH) && rise_s;
            back_go_s    = (state_r == ST_HIGH) && fall_s;
        end

        // Per-channel event FSM: slot allocation, counting, overflow and timeout
        always_ff @(posedge clk or negedge rst_init_n) begin
            if (!rst_init_n) begin
                state_r   <= ST_IDLE;
                ev_r      <= {EW{1'b0}};
                count_r   <= {CW{1'b0}};
                held_r    <= {NEV{1'b0}};
                ovf_r     <= 1'b0;
                timer_r   <= {TO_W{1'b0}};
                timeout_r <= 1'b0;
            end else begin
                ev_r      <= ev_base_s;
                count_r   <= count_base_s;
                held_r    <= held_base_s;
                ovf_r     <= ovf_base_s;
                timeout_r <= 1'b0;
                case (state_r)
                    ST_HIGH: begin
                        if (fall_s) begin
                            state_r <= ST_WAIT;
                            held_r  <= held_base_s & ~prev_mask_s;
                            ev_r    <= ev_inc_s;
                            ovf_r   <= ovf_base_s | wrap_s;
                            timer_r <= tload_s;
                        end else begin
                            state_r <= ST_HIGH;
                        end
                    end
                    ST_IDLE, ST_WAIT: begin
                        if (rise_s) begin
                            // A rise always wins over a coinciding timeout expiry
                            state_r <= ST_HIGH;
                            held_r  <= held_base_s | front_mask_s;
                            count_r <= (count_base_s < CW'(NEV)) ? (count_base_s + CW'(1))
                                                                 : count_base_s;
                        end else if (read_en) begin
                            state_r <= ST_IDLE;
                        end else if ((state_r == ST_WAIT) && timeout_en) begin
                            if (timer_r <= TO_W'(1)) begin
                                held_r    <= {NEV{1'b0}};
                                timeout_r <= 1'b1;
                                state_r   <= ST_IDLE;
                            end else begin
                                timer_r <= timer_r - TO_W'(1);
                            end
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end

        for (genvar e = 0; e < NEV; e++) begin : gen_ev
            logic          front_bit_r, back_bit_r;
            logic [PW-1:0] front_rem_r, back_rem_r;

            // TAC pulse stretchers; a re-trigger restarts the PULSE_W window
            always_ff @(posedge clk or negedge rst_init_n) begin
                if (!rst_init_n) begin
                    front_bit_r <= 1'b0;
                    front_rem_r <= {PW{1'b0}};
                    back_bit_r  <= 1'b0;
                    back_rem_r  <= {PW{1'b0}};
                end else begin
                    if (front_go_s && (ev_base_s == EW'(e))) begin
                        front_bit_r <= 1'b1;
                        front_rem_r <= PW'(PULSE_W - 1);
                    end else if (front_bit_r) begin
                        if (front_rem_r == {PW{1'b0}}) begin
                            front_bit_r <= 1'b0;
                        end else begin
                            front_rem_r <= front_rem_r - PW'(1);
                        end
                    end else begin
                        front_bit_r <= 1'b0;
                    end
                    // Back pulse indexes the event that is ending, before any clear
                    if (back_go_s && (ev_r == EW'(e))) begin
                        back_bit_r <= 1'b1;
                        back_rem_r <= PW'(PULSE_W - 1);
                    end else if (back_bit_r) begin
                        if (back_rem_r == {PW{1'b0}}) begin
                            back_bit_r <= 1'b0;
                        end else begin
                            back_rem_r <= back_rem_r - PW'(1);
                        end
                    end else begin
                        back_bit_r <= 1'b0;
                    end
                end
            end

            assign VP_front[c*NEV + e] = front_bit_r;
            assign VP_back[c*NEV + e]  = back_bit_r;
        end

        // Even event indices are ping slots, odd ones pong slots
        for (genvar s = 0; s < NSLOT; s++) begin : gen_slot
            assign sample[c*NSLOT + s]  = held_r[2*s];
            assign sampleP[c*NSLOT + s] = held_r[2*s + 1];
        end

        assign count[c*CW +: CW] = count_r;
        assign overflow[c]       = ovf_r;
        assign timeout[c]        = timeout_r;
    end

endmodule
